// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM states, forward selects and register-zero constant
package pipe_hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_RUN  = 2'd1,
        ST_MC_DONE = 2'd2
    } state_t;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_S3 = 2'd1;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// src_match: compares one source operand against the S2 and S3 destination ports
module src_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic              en,
    input  logic [REG_AW-1:0] s2_wsel,
    input  logic              s2_we,
    input  logic [REG_AW-1:0] s3_wsel,
    input  logic              s3_we,
    output logic              m2,
    output logic              m3
);
    logic live;
    // register zero is hardwired, so it never carries a dependency
    assign live = en && (addr != REG_AW'(REG_ZERO));
    assign m2 = live && s2_we && (addr == s2_wsel);
    assign m3 = live && s3_we && (addr == s3_wsel);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detection, S3 forwarding, multi-cycle ALU sequencing
// and a saturating stall counter for the three-stage pipeline.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MC_CNT_W = 4,
    parameter bit FWD_EN   = 1'b1,
    parameter int STAT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_en,
    input  logic                id_rs2_en,
    input  logic                id_mc,
    input  logic [MC_CNT_W-1:0] id_mc_len,
    input  logic [REG_AW-1:0]   s2_wsel,
    input  logic                s2_we,
    input  logic [REG_AW-1:0]   s3_wsel,
    input  logic                s3_we,
    input  logic                flush,
    output logic                stall_s1,
    output logic                hold_s2,
    output logic                bubble_s2,
    output logic                alu_start,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [STAT_W-1:0]   stall_cnt
);
    state_t              state;
    logic [MC_CNT_W-1:0] cnt;
    logic                flush_pend;
    logic                m2_a, m3_a, m2_b, m3_b;
    logic                hz_s2, hz_s3, raw, run, eff_flush, issue_mc;

    src_match #(.REG_AW(REG_AW)) u_rs1 (
        .addr(id_rs1), .en(id_rs1_en),
        .s2_wsel(s2_wsel), .s2_we(s2_we), .s3_wsel(s3_wsel), .s3_we(s3_we),
        .m2(m2_a), .m3(m3_a)
    );
    src_match #(.REG_AW(REG_AW)) u_rs2 (
        .addr(id_rs2), .en(id_rs2_en),
        .s2_wsel(s2_wsel), .s2_we(s2_we), .s3_wsel(s3_wsel), .s3_we(s3_we),
        .m2(m2_b), .m3(m3_b)
    );

    assign hz_s2     = m2_a || m2_b;
    assign hz_s3     = (m3_a || m3_b) && !FWD_EN;
    assign raw       = id_valid && (hz_s2 || hz_s3);
    assign run       = (state == ST_MC_RUN);
    // a flush seen while the multi-cycle op held S2 is replayed in MC_DONE
    assign eff_flush = flush || ((state == ST_MC_DONE) && flush_pend);
    assign issue_mc  = (state == ST_IDLE) && id_valid && id_mc
                       && (id_mc_len >= MC_CNT_W'(2)) && !raw && !flush;

    always_comb begin
        stall_s1  = rst && (run || (!eff_flush && raw));
        hold_s2   = rst && run;
        bubble_s2 = !rst || (!run && (eff_flush || raw));
        alu_start = rst && issue_mc;
        fwd_a     = (rst && FWD_EN && m3_a) ? FWD_S3 : FWD_RF;
        fwd_b     = (rst && FWD_EN && m3_b) ? FWD_S3 : FWD_RF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else if (state == ST_IDLE) begin
            state <= issue_mc ? ST_MC_RUN : ST_IDLE;
            cnt   <= issue_mc ? id_mc_len - MC_CNT_W'(2) : cnt;
        end else if (run) begin
            flush_pend <= flush_pend || flush;
            state      <= (cnt == '0) ? ST_MC_DONE : ST_MC_RUN;
            cnt        <= (cnt == '0) ? cnt : cnt - 1'b1;
        end else begin
            state      <= ST_IDLE;
            flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall_s1 && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven combinational vectors plus directed
// multi-cycle, flush, reset and saturation sequences.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_en, id_rs2_en, id_mc, s2_we, s3_we, flush;
    logic [4:0] id_rs1, id_rs2, s2_wsel, s3_wsel;
    logic [3:0] id_mc_len;
    logic       stall_s1, hold_s2, bubble_s2, alu_start;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic       stall2, hold2, bubble2, start2;
    logic [1:0] fwd_a2, fwd_b2;
    logic [3:0] stall_cnt2;
    logic [7:0] ob;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_mc(id_mc), .id_mc_len(id_mc_len),
        .s2_wsel(s2_wsel), .s2_we(s2_we), .s3_wsel(s3_wsel), .s3_we(s3_we), .flush(flush),
        .stall_s1(stall_s1), .hold_s2(hold_s2), .bubble_s2(bubble_s2), .alu_start(alu_start),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .STAT_W(4)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_mc(id_mc), .id_mc_len(id_mc_len),
        .s2_wsel(s2_wsel), .s2_we(s2_we), .s3_wsel(s3_wsel), .s3_we(s3_we), .flush(flush),
        .stall_s1(stall2), .hold_s2(hold2), .bubble_s2(bubble2), .alu_start(start2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
    );

    // {stall_s1, hold_s2, bubble_s2, alu_start, fwd_a, fwd_b}
    assign ob = {stall_s1, hold_s2, bubble_s2, alu_start, fwd_a, fwd_b};

    typedef struct {
        string      name;
        logic       v, e1, e2, mc, s2we, s3we, fl;
        logic [4:0] rs1, rs2, s2w, s3w;
        logic [3:0] len;
        logic [7:0] exp;
        logic       exp2;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(string name, logic v, logic [4:0] rs1, logic e1,
                                logic [4:0] rs2, logic e2, logic mc, logic [3:0] len,
                                logic [4:0] s2w, logic s2we, logic [4:0] s3w, logic s3we,
                                logic fl, logic [7:0] exp, logic exp2);
        vec_t r;
        r.name = name; r.v = v; r.rs1 = rs1; r.e1 = e1; r.rs2 = rs2; r.e2 = e2;
        r.mc = mc; r.len = len; r.s2w = s2w; r.s2we = s2we; r.s3w = s3w; r.s3we = s3we;
        r.fl = fl; r.exp = exp; r.exp2 = exp2;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
        id_mc = 0; id_mc_len = 0; s2_wsel = 0; s2_we = 0; s3_wsel = 0; s3_we = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0);
        tbl[1]  = mk("dep_s2",      1, 5, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 8'b1010_0000, 1);
        tbl[2]  = mk("s2_we_off",   1, 5, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 8'b0000_0000, 0);
        tbl[3]  = mk("rs1_en_off",  1, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 8'b0000_0000, 0);
        tbl[4]  = mk("fwd_rs1_s3",  1, 7, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 8'b0000_0100, 1);
        tbl[5]  = mk("fwd_rs2_s3",  1, 0, 0, 9, 1, 0, 0, 0, 0, 9, 1, 0, 8'b0000_0001, 1);
        tbl[6]  = mk("zero_s3",     1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'b0000_0000, 0);
        tbl[7]  = mk("zero_s2",     1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b0000_0000, 0);
        tbl[8]  = mk("flush_raw",   1, 5, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 8'b0010_0000, 0);
        tbl[9]  = mk("mc_len4",     1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 8'b0001_0000, 0);
        tbl[10] = mk("mc_len1",     1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8'b0000_0000, 0);
        tbl[11] = mk("mc_raw",      1, 5, 1, 0, 0, 1, 4, 5, 1, 0, 0, 0, 8'b1010_0000, 1);
        tbl[12] = mk("mc_flush",    1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0, 1, 8'b0010_0000, 0);
        tbl[13] = mk("s2_and_s3",   1, 5, 1, 7, 1, 0, 0, 5, 1, 7, 1, 0, 8'b1010_0001, 1);
        tbl[14] = mk("rs1_both",    1, 5, 1, 0, 0, 0, 0, 5, 1, 5, 1, 0, 8'b1010_0100, 1);
        tbl[15] = mk("mc_len0",     1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0);

        clear();
        rst = 0;
        #2;
        check("reset_outputs", 32'(ob), 32'(8'b0010_0000));
        check("reset_cnt", 32'(stall_cnt), 0);
        step();
        step();
        rst = 1;

        foreach (tbl[i]) begin
            step();
            id_valid = tbl[i].v; id_rs1 = tbl[i].rs1; id_rs1_en = tbl[i].e1;
            id_rs2 = tbl[i].rs2; id_rs2_en = tbl[i].e2; id_mc = tbl[i].mc;
            id_mc_len = tbl[i].len; s2_wsel = tbl[i].s2w; s2_we = tbl[i].s2we;
            s3_wsel = tbl[i].s3w; s3_we = tbl[i].s3we; flush = tbl[i].fl;
            #1;
            check(tbl[i].name, 32'(ob), 32'(tbl[i].exp));
            check({tbl[i].name, "_nofwd_stall"}, 32'(stall2), 32'(tbl[i].exp2));
            clear();
        end
        step();
        check("table_cnt", 32'(stall_cnt), 0);

        // dependent pair: one stall, then forward from S3
        clear(); id_valid = 1; id_rs1 = 5; id_rs1_en = 1; s2_wsel = 5; s2_we = 1;
        #1 check("pair_stall", 32'(ob), 32'(8'b1010_0000));
        step();
        s2_we = 0; s3_wsel = 5; s3_we = 1;
        #1 check("pair_fwd", 32'(ob), 32'(8'b0000_0100));
        check("pair_cnt", 32'(stall_cnt), 1);

        // multi-cycle op of length 4
        step(); clear();
        step(); id_valid = 1; id_mc = 1; id_mc_len = 4;
        #1 check("mc_start", 32'(ob), 32'(8'b0001_0000));
        for (int i = 1; i <= 3; i++) begin
            step(); clear();
            #1 check($sformatf("mc_run%0d", i), 32'(ob), 32'(8'b1100_0000));
        end
        step();
        #1 check("mc_done", 32'(ob), 0);
        check("mc_cnt", 32'(stall_cnt), 4);

        // flush in the second MC_RUN cycle is deferred to MC_DONE
        step(); id_valid = 1; id_mc = 1; id_mc_len = 4;
        #1 check("fl_start", 32'(ob), 32'(8'b0001_0000));
        step(); clear();
        #1 check("fl_run1", 32'(ob), 32'(8'b1100_0000));
        step(); flush = 1;
        #1 check("fl_run2", 32'(ob), 32'(8'b1100_0000));
        step(); flush = 0;
        #1 check("fl_run3", 32'(ob), 32'(8'b1100_0000));
        step();
        #1 check("fl_done_bubble", 32'(ob), 32'(8'b0010_0000));
        step();
        #1 check("fl_idle", 32'(ob), 0);
        check("fl_cnt", 32'(stall_cnt), 7);

        // reset asserted in the third MC_RUN cycle of a length-8 op
        step(); id_valid = 1; id_mc = 1; id_mc_len = 8;
        #1 check("rst_start", 32'(ob), 32'(8'b0001_0000));
        step(); clear();
        step();
        step();
        #1 check("rst_run3", 32'(ob), 32'(8'b1100_0000));
        id_rs1 = 7; id_rs1_en = 1; s3_wsel = 7; s3_we = 1;
        rst = 0;
        #1 check("rst_mid_outputs", 32'(ob), 32'(8'b0010_0000));
        check("rst_mid_cnt", 32'(stall_cnt), 0);
        @(negedge clk) rst = 1;
        step(); clear(); id_valid = 1; id_rs1 = 3; id_rs1_en = 1;
        #1 check("post_rst_issue", 32'(ob), 0);
        step(); clear();
        #1 check("post_rst_idle", 32'(ob), 0);

        // continuous hazard: 16-bit counter counts, 4-bit counter saturates
        step(); id_valid = 1; id_rs1 = 5; id_rs1_en = 1; s2_wsel = 5; s2_we = 1;
        repeat (20) @(posedge clk);
        #2;
        check("sat_cnt16", 32'(stall_cnt), 20);
        check("sat_cnt4", 32'(stall_cnt2), 15);
        clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the three-stage pipeline (S1 decode, S2 register-read/execute, S3 result/writeback). It does four jobs:
- compares the decoded instruction's source registers against the destinations held in the S2 and S3 stage registers;
- drives hold and bubble controls into the S1/S2 stage registers;
- selects S3 forwarding for ALU operands;
- sequences multi-cycle ALU operations with a countdown FSM.

It also keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- REG_AW, 5, register address width
- MC_CNT_W, 4, multi-cycle length width
- FWD_EN, 1, 1 = forward from S3; 0 = stall on S3 match instead
- STAT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  S1 holds a valid instruction
- id_rs1, id_rs2  in  REG_AW  source register addresses
- id_rs1_en, id_rs2_en  in  1  the source is actually read
- id_mc  in  1  instruction is a multi-cycle ALU op
- id_mc_len  in  MC_CNT_W  total execute cycles for the multi-cycle op
- s2_wsel, s2_we  in  REG_AW/1  destination and write enable of the instruction in S2
- s3_wsel, s3_we  in  REG_AW/1  destination and write enable of the instruction in S3
- flush  in  1  squash the instruction in S1 (taken branch resolved in S2)
- stall_s1  out  1  hold the PC and the S1 register
- hold_s2  out  1  hold the S2 register; S3 must not capture
- bubble_s2  out  1  S2 loads a NOP (write enable 0) instead of S1 contents
- alu_start  out  1  one-cycle pulse that starts the multi-cycle unit
- fwd_a, fwd_b  out  2  operand source: 0 = register file, 1 = S3 ALUOut; 2 and 3 reserved, never driven
- stall_cnt  out  STAT_W  count of cycles with stall_s1 = 1, saturating

## Operation
- A source matches a stage when three things hold: the source is enabled, the stage's write enable is set, and the addresses are equal. Address 0 never matches.
- hz_s2: any source matches S2. hz_s3: any source matches S3 and FWD_EN = 0. raw = id_valid & (hz_s2 | hz_s3).
- fwd_a = 1 when FWD_EN = 1 and rs1 matches S3; otherwise 0. fwd_b is the same using rs2. fwd_a and fwd_b are 0 whenever rst is low.
- FSM states:
  - IDLE: normal issue.
  - MC_RUN: multi-cycle op in S2; hold_s2 = 1 and stall_s1 = 1.
  - MC_DONE: one cycle; hold released, S3 captures the result.
- IDLE → MC_RUN: when id_valid & id_mc & id_mc_len ≥ 2 & !raw & !flush. In that cycle alu_start = 1 and cnt loads id_mc_len − 2. id_mc_len of 0 or 1 executes as a single-cycle op.
- MC_RUN: cnt decrements each cycle. When cnt = 0, go to MC_DONE.
- MC_DONE → IDLE unconditionally. Issue rules are evaluated normally in this cycle.
- IDLE / MC_DONE outputs:
  - flush → bubble_s2 = 1, stall_s1 = 0.
  - else raw → stall_s1 = 1, bubble_s2 = 1.
  - else all three controls are 0.
- flush during MC_RUN sets flush_pend. The multi-cycle op in S2 is never aborted. flush_pend is applied as a flush in MC_DONE, then cleared.
- stall_cnt increments on every cycle with stall_s1 = 1 and holds at all-ones.

## Timing
- Hazard, forward and hold/bubble outputs are combinational from inputs and the registered state, valid in the same cycle.
- alu_start is asserted only in the issuing cycle; it is 0 in MC_RUN and MC_DONE.
- A multi-cycle op of length N keeps hold_s2 = 1 for exactly N − 1 cycles. S3 captures on the edge that ends MC_DONE.
- An S2-destination hazard costs exactly 1 stall cycle, because the producer moves to S3 and forwarding then applies. With FWD_EN = 0, a hazard against S2 costs 2 cycles.
- While rst is low:
  - state = IDLE, cnt = 0, flush_pend = 0, stall_cnt = 0;
  - bubble_s2 = 1;
  - all other outputs are 0.
- Reset asserted mid-MC_RUN returns to IDLE immediately. After the first rising clk edge following rst deassertion, normal issue resumes.

## Structure
- Shared package holds:
  - the state enum (IDLE / MC_RUN / MC_DONE);
  - forward select constants FWD_RF = 0, FWD_S3 = 1;
  - the REG_ZERO constant.
- Sub-module src_match: takes one source address and enable, plus both stage write ports. It outputs the S2 match and the S3 match. Instantiated twice, once for rs1 and once for rs2.
- FSM, countdown counter, flush_pend and stall_cnt live in the top module.

## Test plan
- Dependent pair: S2 holds wsel = 5, we = 1; S1 has id_rs1 = 5, rs1 enabled → stall_s1 = 1 and bubble_s2 = 1 for one cycle. The next cycle has fwd_a = 1 and no stall.
- Register zero: s3_wsel = 0, s3_we = 1, id_rs2 = 0 → fwd_b = 0 and no stall.
- Multi-cycle op with id_mc_len = 4:
  - alu_start pulses once;
  - hold_s2 = 1 for 3 cycles;
  - MC_DONE for 1 cycle;
  - stall_cnt advances by 3.
- Flush pulsed in the second MC_RUN cycle: the op completes, and bubble_s2 = 1 in MC_DONE.
- Reset low during MC_RUN (len 8, cycle 3): the FSM is back in IDLE, hold_s2 = 0 and stall_cnt = 0 with no clock edge. After release, a single-cycle op issues normally.
- STAT_W = 4 under continuous hazard for 20 cycles → stall_cnt saturates at 15.
